// File: rtl/pcd8544_rx_if.sv
// Bundle of LCD-side SPI pins plus the decoded state and frame RAM read port.
// master = host/LCD driver side, slave = the receiver.
interface pcd8544_if;
  logic       sclk, mosi, sce, dc, lcd_rst;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_is_data;
  logic [6:0] x_addr;
  logic [2:0] y_addr;
  logic       h_mode, v_mode, pd;
  logic [1:0] disp_mode;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  logic       err_frame;

  modport master (
    output sclk, mosi, sce, dc, lcd_rst, rd_addr,
    input  rx_byte, rx_valid, rx_is_data, x_addr, y_addr,
           h_mode, v_mode, pd, disp_mode, rd_data, err_frame
  );
  modport slave (
    input  sclk, mosi, sce, dc, lcd_rst, rd_addr,
    output rx_byte, rx_valid, rx_is_data, x_addr, y_addr,
           h_mode, v_mode, pd, disp_mode, rd_data, err_frame
  );
endinterface

// File: rtl/pcd8544_rx.sv
// PCD8544 SPI receiver: byte capture, command decode, RAM address tracking.
// Frame RAM and read port exist only when PCD8544_FRAMEBUF_EN is defined.
module pcd8544_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 84,
  parameter int ROWS        = 6
) (
  input logic      clk,
  input logic      rst,
  pcd8544_if.slave bus
);
  localparam int DEPTH = COLS * ROWS;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] r_s_sclk, r_s_mosi, r_s_sce, r_s_dc, r_s_lrst;
  logic w_sclk, w_mosi, w_sce, w_dc, w_lcd_rst, w_sclk_rise;

  logic [0:0] r_state;
  logic [2:0] r_cnt;
  logic [6:0] r_shift;
  logic       r_sclk_d;
  logic [7:0] r_rx_byte;
  logic       r_rx_valid, r_rx_is_data, r_err;
  logic [6:0] r_x_addr;
  logic [2:0] r_y_addr;
  logic       r_h_mode, r_v_mode, r_pd;
  logic [1:0] r_disp_mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_sclk <= '0;
      r_s_mosi <= '0;
      r_s_sce  <= '1;
      r_s_dc   <= '0;
      r_s_lrst <= '1;
    end else begin
      r_s_sclk <= {r_s_sclk[SYNC_STAGES-2:0], bus.sclk};
      r_s_mosi <= {r_s_mosi[SYNC_STAGES-2:0], bus.mosi};
      r_s_sce  <= {r_s_sce[SYNC_STAGES-2:0],  bus.sce};
      r_s_dc   <= {r_s_dc[SYNC_STAGES-2:0],   bus.dc};
      r_s_lrst <= {r_s_lrst[SYNC_STAGES-2:0], bus.lcd_rst};
    end
  end

  assign w_sclk      = r_s_sclk[SYNC_STAGES-1];
  assign w_mosi      = r_s_mosi[SYNC_STAGES-1];
  assign w_sce       = r_s_sce[SYNC_STAGES-1];
  assign w_dc        = r_s_dc[SYNC_STAGES-1];
  assign w_lcd_rst   = r_s_lrst[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_sclk_d     <= 1'b0;
      r_rx_byte    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_is_data <= 1'b0;
      r_err        <= 1'b0;
      r_x_addr     <= '0;
      r_y_addr     <= '0;
      r_h_mode     <= 1'b0;
      r_v_mode     <= 1'b0;
      r_pd         <= 1'b1;
      r_disp_mode  <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      r_err      <= 1'b0;
      r_sclk_d   <= w_sclk;
      if (!w_lcd_rst) begin
        // LCD reset pin: same values as power-on, partial byte dropped silently
        r_state      <= ST_IDLE;
        r_cnt        <= '0;
        r_shift      <= '0;
        r_rx_byte    <= '0;
        r_rx_is_data <= 1'b0;
        r_x_addr     <= '0;
        r_y_addr     <= '0;
        r_h_mode     <= 1'b0;
        r_v_mode     <= 1'b0;
        r_pd         <= 1'b1;
        r_disp_mode  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (!w_sce) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
          end
          default: if (w_sce) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            if (r_cnt != 3'd0) r_err <= 1'b1;
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[5:0], w_mosi};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              r_rx_byte    <= {r_shift, w_mosi};
              r_rx_is_data <= w_dc;
              r_rx_valid   <= 1'b1;
            end
          end
        endcase

        if (r_rx_valid) begin
          if (r_rx_is_data) begin
            if (!r_v_mode) begin
              if (int'(r_x_addr) == COLS-1) begin
                r_x_addr <= '0;
                r_y_addr <= (int'(r_y_addr) == ROWS-1) ? 3'd0 : r_y_addr + 3'd1;
              end else begin
                r_x_addr <= r_x_addr + 7'd1;
              end
            end else begin
              if (int'(r_y_addr) == ROWS-1) begin
                r_y_addr <= '0;
                r_x_addr <= (int'(r_x_addr) == COLS-1) ? 7'd0 : r_x_addr + 7'd1;
              end else begin
                r_y_addr <= r_y_addr + 3'd1;
              end
            end
          end else if (r_rx_byte[7:3] == 5'b00100) begin
            r_pd     <= r_rx_byte[2];
            r_v_mode <= r_rx_byte[1];
            r_h_mode <= r_rx_byte[0];
          end else if (!r_h_mode) begin
            // extended-set codes (bias/Vop/temp) fall through here untouched
            if (r_rx_byte[7:3] == 5'b00001 && r_rx_byte[2:0] <= 3'd5)
              r_disp_mode <= {r_rx_byte[2], r_rx_byte[0]};
            else if (r_rx_byte[7:3] == 5'b01000 && int'(r_rx_byte[2:0]) < ROWS)
              r_y_addr <= r_rx_byte[2:0];
            else if (r_rx_byte[7] && int'(r_rx_byte[6:0]) < COLS)
              r_x_addr <= r_rx_byte[6:0];
          end
        end
      end
    end
  end

`ifdef PCD8544_FRAMEBUF_EN
  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;
  logic [8:0] w_wr_addr;

  assign w_wr_addr = 9'(int'(r_y_addr) * COLS + int'(r_x_addr));

  // no reset on the array: contents are undefined until written
  always_ff @(posedge clk) begin
    if (r_rx_valid && r_rx_is_data && w_lcd_rst) r_mem[w_wr_addr] <= r_rx_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_rd_data <= '0;
    else if (!w_lcd_rst)          r_rd_data <= '0;
    else if (int'(bus.rd_addr) < DEPTH) r_rd_data <= r_mem[bus.rd_addr];
    else                          r_rd_data <= '0;
  end
  assign bus.rd_data = r_rd_data;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^bus.rd_addr;
  assign bus.rd_data = 8'h00;
`endif

  assign bus.rx_byte    = r_rx_byte;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.rx_is_data = r_rx_is_data;
  assign bus.err_frame  = r_err;
  assign bus.x_addr     = r_x_addr;
  assign bus.y_addr     = r_y_addr;
  assign bus.h_mode     = r_h_mode;
  assign bus.v_mode     = r_v_mode;
  assign bus.pd         = r_pd;
  assign bus.disp_mode  = r_disp_mode;
endmodule

// File: doc/pcd8544_rx.md
PCD8544_RX -- requirements
Module: pcd8544_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth, range 2..3.
REQ-002 SHALL have parameter COLS, default 84: columns per bank.
REQ-003 SHALL have parameter ROWS, default 6: banks per frame.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports sclk, mosi, sce, dc, lcd_rst, inputs, 1 each: asynchronous LCD SPI pins; sce and lcd_rst active-low.
REQ-007 SHALL have port rx_byte, output, 8: last completed byte.
REQ-008 SHALL have port rx_valid, output, 1: one-cycle strobe per completed byte.
REQ-009 SHALL have port rx_is_data, output, 1: dc value latched with rx_byte.
REQ-010 SHALL have ports x_addr (7) and y_addr (3), outputs: current RAM write address.
REQ-011 SHALL have ports h_mode, v_mode, pd, output, 1 each, and disp_mode, output, 2: decoded mode bits {D,E}.
REQ-012 SHALL have ports rd_addr, input, 9, and rd_data, output, 8: frame RAM read port.
REQ-013 SHALL have port err_frame, output, 1: one-cycle strobe on aborted byte.

Function
REQ-014 SHALL pass sclk, mosi, sce, dc, lcd_rst through SYNC_STAGES flops before use; sclk high/low phases guaranteed >= SYNC_STAGES+1 clk cycles.
REQ-015 SHALL implement FSM IDLE (sce high) -> SHIFT (sce low) -> IDLE; sce fall clears bit counter to 0.
REQ-016 SHALL, in SHIFT, on each synchronized sclk rising edge, shift mosi in MSB first and increment 3-bit counter.
REQ-017 SHALL, on the 8th edge, latch dc, update rx_byte/rx_is_data and assert rx_valid on the following cycle; counter wraps to 0 so back-to-back bytes need no sce toggle.
REQ-018 SHALL, on sce rise with counter != 0, discard partial byte and pulse err_frame; no rx_valid.
REQ-019 SHALL decode commands (dc=0) in the rx_valid cycle: 0x20-0x27 sets pd=bit2, v_mode=bit1, h_mode=bit0 in either H mode.
REQ-020 SHALL, with h_mode=0 only: 0x08-0x0D sets disp_mode={bit2,bit0}; 0x40|y sets y_addr if y<ROWS; 0x80|x sets x_addr if x<COLS; out-of-range or other codes ignored.
REQ-021 SHALL ignore all non-function-set commands while h_mode=1 (bias/Vop/temp accepted silently).
REQ-022 SHALL, for data (dc=1), write rx_byte to RAM at y_addr*COLS+x_addr in the rx_valid cycle, regardless of pd.
REQ-023 SHALL auto-increment after each data write, visible next cycle: v_mode=0: x++, at COLS-1 x=0 and y++; v_mode=1: y++, at ROWS-1 y=0 and x++; both wrap from (COLS-1,ROWS-1) to (0,0).
REQ-024 SHALL give rd_data registered, one-cycle latency after rd_addr; rd_addr >= COLS*ROWS returns 0x00; simultaneous write/read of same address returns old data.
REQ-025 SHALL, on synchronized lcd_rst low, synchronously apply reset values of REQ-027 except frame RAM, and abort any partial byte without err_frame.

Reset
REQ-026 SHALL act on rst low immediately, independent of clk.
REQ-027 SHALL reset: FSM IDLE, counter 0, rx_byte 0x00, rx_valid 0, rx_is_data 0, err_frame 0, x_addr 0, y_addr 0, h_mode 0, v_mode 0, pd 1, disp_mode 00, rd_data 0x00, synchronizers to idle levels (sce 1, lcd_rst 1, sclk 0).
REQ-028 SHALL NOT clear frame RAM on reset; contents undefined until written.

Configuration
REQ-029 SHALL compile the frame RAM (COLS*ROWS bytes) and read port only when macro PCD8544_FRAMEBUF_EN is defined.
REQ-030 SHALL, without PCD8544_FRAMEBUF_EN, omit RAM, drive rd_data constant 0x00, and keep all decode and address tracking of REQ-019..REQ-023 unchanged.

Verification
REQ-031 Byte 0xA5 with dc=1 at x=0,y=0 -> rx_valid once, rx_byte 0xA5, rx_is_data 1, rd_addr 0 reads 0xA5, x_addr 1.
REQ-032 Commands 0x21, 0x22 -> h_mode 1 then h_mode 0, v_mode 1; 0x0C sent with h_mode=1 ignored, sent with h_mode=0 -> disp_mode 10.
REQ-033 Commands 0x45, 0xD3, 504th... : 0x45, 0xD3 then 1 data byte -> write at addr 503, x/y wrap to 0/0; 0x46 and 0xD4 leave addresses unchanged.
REQ-034 sce raised after 5 bits -> err_frame pulse, no rx_valid; next full byte 0x3C decoded correctly.
REQ-035 rst low mid-byte after 3 bits -> outputs at REQ-027 values at once; following byte 0x81 sets x_addr 1.
REQ-036 v_mode=1, y=5, x=10, data byte -> y_addr 0, x_addr 11; build without macro -> rd_data 0x00 always.
